// File: rtl/bidir_io_bank_if.sv
// Core-side bundle of the bidirectional pad bank: drive requests in, filtered pad state out.
interface bidir_io_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] oe_active;

  modport master (output oe, dout, input din, rise, fall, oe_active);
  modport slave  (input oe, dout, output din, rise, fall, oe_active);
endinterface

// File: rtl/bidir_io_bank.sv
// Bank of WIDTH bidirectional pads: synchronised and filtered input with edge pulses,
// registered output drive with a per-bit turnaround delay before the driver turns on.
module bidir_io_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  bidir_io_bank_if.slave   bus,
  inout  wire [WIDTH-1:0]  io
);
  localparam int unsigned FW = $clog2(FILT_CYCLES + 1);
  localparam int unsigned TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TURN_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("bidir_io_bank: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("bidir_io_bank: FILT_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] act_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dout_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io};
      dout_q <= bus.dout;
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic          change;

    // din only moves after FILT_CYCLES consecutive disagreeing samples
    assign change = (sync_out[n] != din_q[n]) && (fcnt == FMAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fcnt      <= '0;
        din_q[n]  <= 1'b0;
        rise_q[n] <= 1'b0;
        fall_q[n] <= 1'b0;
      end else begin
        rise_q[n] <= change & sync_out[n];
        fall_q[n] <= change & ~sync_out[n];
        if (sync_out[n] == din_q[n]) begin
          fcnt <= '0;
        end else if (fcnt == FMAX) begin
          din_q[n] <= sync_out[n];
          fcnt     <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end

    // Turn-on waits TURN_CYCLES extra requesting edges; release is immediate
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tcnt     <= '0;
        act_q[n] <= 1'b0;
      end else if (!bus.oe[n]) begin
        tcnt     <= '0;
        act_q[n] <= 1'b0;
      end else if (tcnt == TMAX) begin
        act_q[n] <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end

    assign io[n] = act_q[n] ? dout_q[n] : 1'bz;
  end

  assign bus.din       = din_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.oe_active = act_q;
endmodule
